// File: rtl/control_block.sv
// Round/write-back sequencer for a SHA-256 compression core: sweeps the 64 rounds,
// then drives an 8-word hash write-back and parks in DONE until reset.
module control_block #(
  parameter int ROUNDS    = 64,
  parameter int MSG_WORDS = 16,
  parameter int OUT_WORDS = 8
) (
  input  logic                         cnt,
  input  logic                         reset,
  output logic [$clog2(MSG_WORDS)-1:0] in_mem_addr,
  output logic [$clog2(ROUNDS)-1:0]    k_num,
  output logic [3:0]                   out_mem_addr,
  output logic                         en_mem_out
);

  localparam int STEP_W = $clog2(ROUNDS);
  localparam int AIN_W  = $clog2(MSG_WORDS);
  localparam int WCNT_W = $clog2(OUT_WORDS);

  typedef enum logic [1:0] {
    ST_ROUND = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [AIN_W-1:0]    in_mem_addr_q, in_mem_addr_d;
  logic [STEP_W-1:0]   k_num_q, k_num_d;
  logic [3:0]          out_mem_addr_q, out_mem_addr_d;
  logic                en_mem_out_q, en_mem_out_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    step_d  = step_q;
    wcnt_d  = wcnt_q;

    unique case (state_q)
      ST_ROUND: begin
        if (step_q == STEP_W'(ROUNDS - 1)) begin
          state_d = ST_WRITE;
          wcnt_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ST_WRITE: begin
        if (wcnt_q == WCNT_W'(OUT_WORDS - 1)) state_d = ST_DONE;
        else                                   wcnt_d  = wcnt_q + 1'b1;
      end
      ST_DONE: ;
      default: state_d = ST_DONE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change with the state.
  always_comb begin
    k_num_d        = step_d;
    in_mem_addr_d  = (step_d < STEP_W'(MSG_WORDS)) ? step_d[AIN_W-1:0] : AIN_W'(MSG_WORDS - 1);
    en_mem_out_d   = (state_d == ST_WRITE);
    out_mem_addr_d = (state_d == ST_ROUND) ? 4'd0 : 4'(wcnt_d);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge cnt or posedge reset) begin
    if (reset) begin
      state_q        <= ST_ROUND;
      step_q         <= '0;
      wcnt_q         <= '0;
      in_mem_addr_q  <= '0;
      k_num_q        <= '0;
      out_mem_addr_q <= '0;
      en_mem_out_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      wcnt_q         <= wcnt_d;
      in_mem_addr_q  <= in_mem_addr_d;
      k_num_q        <= k_num_d;
      out_mem_addr_q <= out_mem_addr_d;
      en_mem_out_q   <= en_mem_out_d;
    end
  end

  assign in_mem_addr  = in_mem_addr_q;
  assign k_num        = k_num_q;
  assign out_mem_addr = out_mem_addr_q;
  assign en_mem_out   = en_mem_out_q;

endmodule

// File: tb/tb_control_block.sv
// Directed bench for control_block: reset, round sweep, write-back, DONE parking
// and asynchronous reset in the middle of write-back.
module tb_control_block;

  logic       cnt;
  logic       reset;
  logic [3:0] in_mem_addr;
  logic [5:0] k_num;
  logic [3:0] out_mem_addr;
  logic       en_mem_out;

  int errors = 0;
  int checks = 0;

  control_block dut (
    .cnt          (cnt),
    .reset        (reset),
    .in_mem_addr  (in_mem_addr),
    .k_num        (k_num),
    .out_mem_addr (out_mem_addr),
    .en_mem_out   (en_mem_out)
  );

  // Each pulse is one rising and one falling edge; outputs are sampled while cnt is low.
  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      #5 cnt = 1'b1;
      #5 cnt = 1'b0;
    end
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input int in_a, input int k, input int out_a,
                           input int en);
    check({tag, ".in_mem_addr"},  int'(in_mem_addr),  in_a);
    check({tag, ".k_num"},        int'(k_num),        k);
    check({tag, ".out_mem_addr"}, int'(out_mem_addr), out_a);
    check({tag, ".en_mem_out"},   int'(en_mem_out),   en);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #20 reset = 1'b0;
    #5;
  endtask

  initial begin
    cnt   = 1'b0;
    reset = 1'b1;
    #100;
    check_all("reset_hold", 0, 0, 0, 0);
    pulse(3);
    check_all("reset_edges_ignored", 0, 0, 0, 0);
    reset = 1'b0;
    #5;
    check_all("after_release", 0, 0, 0, 0);

    pulse(1);
    check_all("first_edge", 1, 1, 0, 0);

    // Round sweep: k_num follows the step, in_mem_addr saturates at 15.
    do_reset();
    for (int i = 1; i <= 63; i++) begin
      pulse(1);
      check("sweep.k_num", int'(k_num), i);
      check("sweep.in_mem_addr", int'(in_mem_addr), (i < 16) ? i : 15);
      check("sweep.en_mem_out", int'(en_mem_out), 0);
    end

    do_reset();
    pulse(15);
    check_all("p15", 15, 15, 0, 0);

    do_reset();
    pulse(20);
    check_all("p20", 15, 20, 0, 0);

    do_reset();
    pulse(63);
    check_all("p63", 15, 63, 0, 0);
    pulse(1);
    check_all("p64_write0", 15, 63, 0, 1);
    for (int w = 1; w <= 7; w++) begin
      pulse(1);
      check_all("write", 15, 63, w, 1);
    end
    pulse(1);
    check_all("p72_done", 15, 63, 7, 0);
    pulse(10);
    check_all("done_stable", 15, 63, 7, 0);

    // Asynchronous reset mid write-back, with no clock edge.
    do_reset();
    pulse(66);
    check_all("p66_write2", 15, 63, 2, 1);
    #2 reset = 1'b1;
    #1;
    check_all("async_reset", 0, 0, 0, 0);
    #10 reset = 1'b0;
    #5;
    check_all("async_release", 0, 0, 0, 0);
    pulse(1);
    check_all("after_async_1", 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
